mdu_ctrl: RTL

Sequencer for the EXE-stage multiply/divide resources. It accepts one mul/div request from the EXE stage and drives the fixed-latency pipelined multiplier and the AXI-Stream divider IPs (signed and unsigned instances). It holds the 64-bit result until the EXE stage advances. It also absorbs pipeline flushes, including draining a divider result that is already in flight so it cannot be delivered to a later instruction.

---
 rtl/mdu_pkg.sv | 32 +++
 rtl/mdu_ctrl_axis_pair_issue.sv | 68 ++++++
 rtl/mdu_ctrl.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/mdu_pkg.sv
// Shared encodings for the EXE-stage multiply/divide sequencer.
package mdu_pkg;

  // Operation encodings carried on req_op
  localparam logic [1:0] MDU_MULT  = 2'b00;
  localparam logic [1:0] MDU_MULTU = 2'b01;
  localparam logic [1:0] MDU_DIV   = 2'b10;
  localparam logic [1:0] MDU_DIVU  = 2'b11;

  // Sequencer states
  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_MUL_WAIT  = 3'd1;
  localparam logic [2:0] ST_DIV_ISSUE = 3'd2;
  localparam logic [2:0] ST_DIV_WAIT  = 3'd3;
  localparam logic [2:0] ST_DONE      = 3'd4;
  localparam logic [2:0] ST_DRAIN     = 3'd5;

  // Legal multiplier latency range (fits the 4-bit countdown)
  localparam int MUL_LAT_MIN = 1;
  localparam int MUL_LAT_MAX = 15;

  // op[1] selects the divider
  function automatic logic mdu_is_div(input logic [1:0] op);
    return op[1];
  endfunction

  // op[0]==0 selects the signed flavour
  function automatic logic mdu_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/mdu_ctrl_axis_pair_issue.sv
// Issues one transaction on the dividend and divisor AXI-Stream channels.
// Each channel drops tvalid independently after its own handshake.
module axis_pair_issue (
  input  logic clk,
  input  logic resetn,
  input  logic start,
  input  logic clear,
  input  logic dvd_tready,
  input  logic dvs_tready,
  output logic dvd_tvalid,
  output logic dvs_tvalid,
  output logic both_accepted,
  output logic any_accepted
);

  logic dvd_acc_r;
  logic dvs_acc_r;
  logic dvd_hs_s;
  logic dvs_hs_s;

  assign dvd_hs_s = dvd_tvalid & dvd_tready;
  assign dvs_hs_s = dvs_tvalid & dvs_tready;

  // A handshake in the current cycle already counts as accepted
  assign both_accepted = (dvd_acc_r | dvd_hs_s) & (dvs_acc_r | dvs_hs_s);
  assign any_accepted  = dvd_acc_r | dvs_acc_r | dvd_hs_s | dvs_hs_s;

  // Dividend channel: raise on start, retire on handshake, drop on clear
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      dvd_tvalid <= 1'b0;
      dvd_acc_r  <= 1'b0;
    end else if (start) begin
      dvd_tvalid <= 1'b1;
      dvd_acc_r  <= 1'b0;
    end else if (clear) begin
      dvd_tvalid <= 1'b0;
      dvd_acc_r  <= 1'b0;
    end else if (dvd_hs_s) begin
      dvd_tvalid <= 1'b0;
      dvd_acc_r  <= 1'b1;
    end else begin
      dvd_tvalid <= dvd_tvalid;
      dvd_acc_r  <= dvd_acc_r;
    end
  end

  // Divisor channel: same life cycle as the dividend channel
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      dvs_tvalid <= 1'b0;
      dvs_acc_r  <= 1'b0;
    end else if (start) begin
      dvs_tvalid <= 1'b1;
      dvs_acc_r  <= 1'b0;
    end else if (clear) begin
      dvs_tvalid <= 1'b0;
      dvs_acc_r  <= 1'b0;
    end else if (dvs_hs_s) begin
      dvs_tvalid <= 1'b0;
      dvs_acc_r  <= 1'b1;
    end else begin
      dvs_tvalid <= dvs_tvalid;
      dvs_acc_r  <= dvs_acc_r;
    end
  end

endmodule

// File: rtl/mdu_ctrl.sv
// Multiply/divide sequencer for the EXE stage: drives a fixed-latency
// multiplier and the AXI-Stream dividers, holds the result until EXE
// advances, and drains divider results orphaned by a flush.
module mdu_ctrl
  import mdu_pkg::*;
#(
  parameter int MUL_LAT = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req_valid,
  input  logic [1:0]  req_op,
  input  logic [31:0] req_src1,
  input  logic [31:0] req_src2,
  input  logic        ack,
  input  logic        flush,
  output logic        done,
  output logic [31:0] res_hi,
  output logic [31:0] res_lo,
  output logic        busy,
  output logic        mul_signed,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  input  logic [63:0] mul_p,
  output logic        div_signed,
  output logic        s_axis_dividend_tvalid,
  input  logic        s_axis_dividend_tready,
  output logic        s_axis_divisor_tvalid,
  input  logic        s_axis_divisor_tready,
  output logic [31:0] div_dividend,
  output logic [31:0] div_divisor,
  input  logic        m_axis_dout_tvalid,
  input  logic [63:0] m_axis_dout_tdata
);

  // Out-of-range latencies are clamped into the countdown's range
  localparam int MUL_LAT_EFF = (MUL_LAT < MUL_LAT_MIN) ? MUL_LAT_MIN :
                               (MUL_LAT > MUL_LAT_MAX) ? MUL_LAT_MAX : MUL_LAT;
  localparam logic [3:0] MUL_LAT_C = 4'(MUL_LAT_EFF);

  logic [2:0] state_r;
  logic [2:0] state_nx_s;
  logic [3:0] cnt_r;
  logic       kill_r;
  logic       accept_s;
  logic       start_div_s;
  logic       clear_div_s;
  logic       cap_mul_s;
  logic       cap_div_s;
  logic       kill_set_s;
  logic       both_acc_s;
  logic       any_acc_s;

  axis_pair_issue u_issue (
    .clk           (clk),
    .resetn        (resetn),
    .start         (start_div_s),
    .clear         (clear_div_s),
    .dvd_tready    (s_axis_dividend_tready),
    .dvs_tready    (s_axis_divisor_tready),
    .dvd_tvalid    (s_axis_dividend_tvalid),
    .dvs_tvalid    (s_axis_divisor_tvalid),
    .both_accepted (both_acc_s),
    .any_accepted  (any_acc_s)
  );

  // Next-state and control decode; flush outranks ack, capture and accept
  always_comb begin
    state_nx_s  = state_r;
    accept_s    = 1'b0;
    start_div_s = 1'b0;
    clear_div_s = 1'b0;
    cap_mul_s   = 1'b0;
    cap_div_s   = 1'b0;
    kill_set_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (req_valid && !flush) begin
          accept_s = 1'b1;
          if (mdu_is_div(req_op)) begin
            start_div_s = 1'b1;
            state_nx_s  = ST_DIV_ISSUE;
          end else begin
            state_nx_s  = ST_MUL_WAIT;
          end
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_MUL_WAIT: begin
        if (flush) begin
          state_nx_s = ST_IDLE;
        end else if (cnt_r == 4'd1) begin
          cap_mul_s  = 1'b1;
          state_nx_s = ST_DONE;
        end else begin
          state_nx_s = ST_MUL_WAIT;
        end
      end
      ST_DIV_ISSUE: begin
        if (flush && !any_acc_s) begin
          // Nothing reached the divider yet: simply withdraw
          clear_div_s = 1'b1;
          state_nx_s  = ST_IDLE;
        end else if (both_acc_s) begin
          // A killed transaction must still be drained from the IP
          clear_div_s = 1'b1;
          state_nx_s  = (kill_r || flush) ? ST_DRAIN : ST_DIV_WAIT;
        end else begin
          kill_set_s = flush;
          state_nx_s = ST_DIV_ISSUE;
        end
      end
      ST_DIV_WAIT: begin
        if (m_axis_dout_tvalid) begin
          if (flush) begin
            // Result arrives with the flush: it is consumed and dropped here
            state_nx_s = ST_IDLE;
          end else begin
            cap_div_s  = 1'b1;
            state_nx_s = ST_DONE;
          end
        end else if (flush) begin
          state_nx_s = ST_DRAIN;
        end else begin
          state_nx_s = ST_DIV_WAIT;
        end
      end
      ST_DONE: begin
        if (flush || ack) begin
          state_nx_s = ST_IDLE;
        end else begin
          state_nx_s = ST_DONE;
        end
      end
      ST_DRAIN: begin
        if (m_axis_dout_tvalid) begin
          state_nx_s = ST_IDLE;
        end else begin
          state_nx_s = ST_DRAIN;
        end
      end
      default: begin
        clear_div_s = 1'b1;
        state_nx_s  = ST_IDLE;
      end
    endcase
  end

  // State, countdown, kill flag and registered status outputs
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r <= ST_IDLE;
      cnt_r   <= 4'd0;
      kill_r  <= 1'b0;
      done    <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      done    <= (state_nx_s == ST_DONE);
      busy    <= (state_nx_s != ST_IDLE);
      kill_r  <= (state_nx_s == ST_DIV_ISSUE) & (kill_r | kill_set_s);
      if (accept_s && !mdu_is_div(req_op)) begin
        cnt_r <= MUL_LAT_C;
      end else if (state_nx_s == ST_MUL_WAIT) begin
        cnt_r <= cnt_r - 4'd1;
      end else begin
        cnt_r <= 4'd0;
      end
    end
  end

  // Operand registers, loaded once at acceptance and held for the IPs
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mul_signed   <= 1'b0;
      mul_a        <= 32'd0;
      mul_b        <= 32'd0;
      div_signed   <= 1'b0;
      div_dividend <= 32'd0;
      div_divisor  <= 32'd0;
    end else if (accept_s && mdu_is_div(req_op)) begin
      div_signed   <= mdu_is_signed(req_op);
      div_dividend <= req_src1;
      div_divisor  <= req_src2;
    end else if (accept_s) begin
      mul_signed   <= mdu_is_signed(req_op);
      mul_a        <= req_src1;
      mul_b        <= req_src2;
    end else begin
      mul_signed   <= mul_signed;
      div_signed   <= div_signed;
    end
  end

  // Result registers: divider tdata is {quotient, remainder}
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      res_hi <= 32'd0;
      res_lo <= 32'd0;
    end else if (cap_mul_s) begin
      res_hi <= mul_p[63:32];
      res_lo <= mul_p[31:0];
    end else if (cap_div_s) begin
      res_hi <= m_axis_dout_tdata[31:0];
      res_lo <= m_axis_dout_tdata[63:32];
    end else begin
      res_hi <= res_hi;
      res_lo <= res_lo;
    end
  end

endmodule
